accum_array: RTL
================

ACCUM_ARRAY -- requirements
Module: accum_array

Interface
REQ-001 Parameter CHANNELS, default 16: number of independent accumulation lanes.
REQ-002 Parameter IN_W, default 8: signed two's-complement input term width per lane.
REQ-003 Parameter OUT_W, default 20: signed accumulator/output width per lane; OUT_W >= IN_W+1.
REQ-004 Parameter TERMS, default 784: number of accepted input beats per pass; TERMS >= 1.
REQ-005 Parameter SATURATE, default 1: 1 = clamp on overflow, 0 = two's-complement wrap.
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 clr  input  1  reset, asynchronous, active-low.
REQ-008 start  input  1  single-cycle request to begin a pass; bias_in is sampled with it.
REQ-009 bias_in  input  CHANNELS*OUT_W  per-lane signed preload; lane m at bits [m*OUT_W +: OUT_W].
REQ-010 in_valid  input  1  data_in beat valid.
REQ-011 in_ready  output  1  block accepts a beat this cycle.
REQ-012 data_in  input  CHANNELS*IN_W  per-lane signed terms; lane m at bits [m*IN_W +: IN_W].
REQ-013 sum_out  output  CHANNELS*OUT_W  per-lane accumulator value, registered.
REQ-014 out_valid  output  1  sum_out holds a completed pass result.
REQ-015 out_ready  input  1  consumer takes the result.
REQ-016 ovf  output  CHANNELS  per-lane sticky overflow flag for the current/last pass.
REQ-017 busy  output  1  high in ACCUM or DONE.

Function
REQ-018 The FSM SHALL have states IDLE, ACCUM, DONE.
REQ-019 IDLE: start=1 SHALL load every lane with bias_in, clear ovf, clear beat counter, go to ACCUM next cycle.
REQ-020 start SHALL be ignored in ACCUM and DONE.
REQ-021 in_ready SHALL be 1 exactly in ACCUM; a beat is accepted when in_valid && in_ready.
REQ-022 Per accepted beat, each lane SHALL add its term, sign-extended from IN_W to OUT_W over all upper bits, to its accumulator; result visible on sum_out the next cycle.
REQ-023 Cycles with in_valid=0 in ACCUM SHALL leave accumulators and counter unchanged.
REQ-024 Beat counter width SHALL be clog2(TERMS+1); on the accepted beat where counter = TERMS-1, FSM SHALL go to DONE.
REQ-025 DONE: out_valid=1, sum_out and ovf held stable; out_ready=1 returns to IDLE next cycle; out_valid low in IDLE/ACCUM.
REQ-026 sum_out SHALL retain the last result in IDLE until the next start.
REQ-027 Overflow of a lane (true sum outside signed OUT_W range) SHALL set that lane's ovf bit, sticky until next start.
REQ-028 SATURATE=1: overflowing lane SHALL clamp to 2^(OUT_W-1)-1 or -2^(OUT_W-1); SATURATE=0: wrap modulo 2^OUT_W.
REQ-029 Lanes SHALL be fully independent; one lane's overflow never affects another.

Reset
REQ-030 clr=0 SHALL asynchronously force IDLE, sum_out=0, ovf=0, counter=0, out_valid=0, in_ready=0, busy=0, including mid-pass; partial sums discarded.
REQ-031 After clr deasserts, the first start SHALL behave per REQ-019.

Structure
REQ-032 Shared package/header SHALL hold FSM state encodings and default values of CHANNELS, IN_W, OUT_W, TERMS.
REQ-033 One sub-module accum_lane (one lane: sign-extend, add, overflow detect, saturate/wrap, register) SHALL be instantiated CHANNELS times via generate; FSM and counter reside in accum_array.

Verification (CHANNELS=2, IN_W=8, OUT_W=12, TERMS=4, SATURATE=1 unless noted)
REQ-034 Lane0 bias 10, terms 5,-3,7,-1 back-to-back -> sum 18, ovf=0, out_valid rises cycle after 4th accept.
REQ-035 Same stimulus with in_valid gaps of 1-3 cycles -> identical sum 18; counter advances only on accepts.
REQ-036 Lane0 bias 2040 term 127 -> 2047, ovf[0]=1; lane1 bias -2040 term -128 -> -2048, ovf[1]=1; flags persist to DONE.
REQ-037 SATURATE=0, bias 2047, term 1 -> -2048, ovf[0]=1.
REQ-038 out_ready low 3 cycles in DONE with start pulsed -> sum_out stable, in_ready=0, start ignored; out_ready=1 -> IDLE.
REQ-039 clr low after 2 accepted beats -> all outputs 0, IDLE immediately; new start with bias 0, terms 1,1,1,1 -> 4.

Source files
------------

// File: rtl/accum_array_pkg.sv
// Shared definitions for the accumulator array: FSM encoding and default geometry.
package accum_array_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int DEF_CHANNELS = 16;
  localparam int DEF_IN_W     = 8;
  localparam int DEF_OUT_W    = 20;
  localparam int DEF_TERMS    = 784;

endpackage

// File: rtl/accum_array_if.sv
// Control/data bundle between an accumulator array and its producer/consumer.
interface accum_array_if
  import accum_array_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int IN_W     = DEF_IN_W,
  parameter int OUT_W    = DEF_OUT_W
);
  logic                      start;
  logic [CHANNELS*OUT_W-1:0] bias_in;
  logic                      in_valid;
  logic                      in_ready;
  logic [CHANNELS*IN_W-1:0]  data_in;
  logic [CHANNELS*OUT_W-1:0] sum_out;
  logic                      out_valid;
  logic                      out_ready;
  logic [CHANNELS-1:0]       ovf;
  logic                      busy;

  modport master (
    output start, bias_in, in_valid, data_in, out_ready,
    input  in_ready, sum_out, out_valid, ovf, busy
  );

  modport slave (
    input  start, bias_in, in_valid, data_in, out_ready,
    output in_ready, sum_out, out_valid, ovf, busy
  );
endinterface

// File: rtl/accum_lane.sv
// One accumulation lane: sign-extend term, add, detect signed overflow,
// then clamp or wrap before registering. Overflow flag is sticky until load.
module accum_lane #(
  parameter int IN_W     = 8,
  parameter int OUT_W    = 20,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic [OUT_W-1:0] bias,
  input  logic [IN_W-1:0]  term,
  output logic [OUT_W-1:0] acc,
  output logic             ovf
);
  localparam logic [OUT_W-1:0] MAXV = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MINV = {1'b1, {(OUT_W-1){1'b0}}};

  logic [OUT_W:0]   sum;
  logic             over;
  logic [OUT_W-1:0] nxt;

  // One guard bit: overflow iff the two top bits of the widened sum disagree.
  assign sum  = {acc[OUT_W-1], acc} + {{(OUT_W+1-IN_W){term[IN_W-1]}}, term};
  assign over = sum[OUT_W] ^ sum[OUT_W-1];

  always_comb begin
    nxt = sum[OUT_W-1:0];
    if (SATURATE != 0 && over)
      nxt = sum[OUT_W] ? MINV : MAXV;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      acc <= bias;
      ovf <= 1'b0;
    end else if (en) begin
      acc <= nxt;
      if (over) ovf <= 1'b1;
    end
  end
endmodule

// File: rtl/accum_array.sv
// Multi-lane accumulator: IDLE loads biases on start, ACCUM sums TERMS accepted
// beats per lane, DONE presents the result until the consumer takes it.
module accum_array
  import accum_array_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int IN_W     = DEF_IN_W,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int TERMS    = DEF_TERMS,
  parameter int SATURATE = 1
) (
  input  logic clk,
  input  logic clr,
  accum_array_if.slave bus
);
  localparam int CNT_W = $clog2(TERMS + 1);

  state_t                          state, state_nxt;
  logic [CNT_W-1:0]                cnt;
  logic                            load, accept, last;
  logic [CHANNELS-1:0][OUT_W-1:0]  sum;
  logic [CHANNELS-1:0]             ovf;

  assign load   = (state == S_IDLE) && bus.start;
  assign accept = (state == S_ACCUM) && bus.in_valid;
  assign last   = accept && (cnt == CNT_W'(TERMS - 1));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (load)        cnt <= '0;
      else if (accept) cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
        if (bus.out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  for (genvar m = 0; m < CHANNELS; m++) begin : g_lane
    accum_lane #(
      .IN_W     (IN_W),
      .OUT_W    (OUT_W),
      .SATURATE (SATURATE)
    ) u_lane (
      .clk  (clk),
      .clr  (clr),
      .load (load),
      .en   (accept),
      .bias (bus.bias_in[m*OUT_W +: OUT_W]),
      .term (bus.data_in[m*IN_W +: IN_W]),
      .acc  (sum[m]),
      .ovf  (ovf[m])
    );
  end

  assign bus.sum_out = sum;
  assign bus.ovf     = ovf;
endmodule
